// File: rtl/branch_resolve_unit.sv
// Two-stage pipelined RV32I branch resolver: S1 registers operands, S2 registers the
// taken/target decision that drives the outputs. Valid/ready on both sides, flush kills both stages.
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_op1,
  input  logic [XLEN-1:0]  in_op2,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [PC_W-1:0]  in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [PC_W-1:0]  out_target,
  output logic             out_illegal,
  output logic             out_misalign,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [1:0] OP1_LT_OP2 = 2'b01;
  localparam logic [1:0] OP1_EQ_OP2 = 2'b10;
  localparam logic [1:0] OP1_GT_OP2 = 2'b11;

  // Shared compare-code helper: one comparator serves both signed and unsigned branches.
  function automatic logic [1:0] cmp_code(input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b,
                                          input logic            is_unsigned);
    logic lt;
    if (is_unsigned) begin
      lt = (a < b);
    end else begin
      lt = ($signed(a) < $signed(b));
    end
    if (a == b) begin
      cmp_code = OP1_EQ_OP2;
    end else if (lt) begin
      cmp_code = OP1_LT_OP2;
    end else begin
      cmp_code = OP1_GT_OP2;
    end
  endfunction

  logic            s1_valid_r;
  logic [2:0]      s1_funct3_r;
  logic [XLEN-1:0] s1_op1_r;
  logic [XLEN-1:0] s1_op2_r;
  logic [PC_W-1:0] s1_pc_r;
  logic [PC_W-1:0] s1_imm_r;

  logic             s2_valid_r;
  logic             s2_taken_r;
  logic [PC_W-1:0]  s2_target_r;
  logic             s2_illegal_r;
  logic             s2_misalign_r;
  logic [CNT_W-1:0] taken_cnt_r;

  logic            s2_adv_s;
  logic            s1_adv_s;
  logic            accept_s;
  logic            deliver_s;
  logic [1:0]      cmp_s;
  logic            taken_s;
  logic            illegal_s;
  logic [PC_W-1:0] target_s;
  logic            misalign_s;

  assign s2_adv_s  = ~s2_valid_r | out_ready;
  assign s1_adv_s  = s1_valid_r & s2_adv_s;
  assign in_ready  = ~s1_valid_r | s2_adv_s;
  assign accept_s  = in_valid & in_ready;
  assign deliver_s = s2_valid_r & out_ready;

  // Branch decision from the S1 registers; funct3[1] selects unsigned compare.
  always_comb begin
    cmp_s      = cmp_code(s1_op1_r, s1_op2_r, s1_funct3_r[1]);
    taken_s    = 1'b0;
    illegal_s  = 1'b0;
    case (s1_funct3_r)
      3'b000:         taken_s = (cmp_s == OP1_EQ_OP2);
      3'b001:         taken_s = (cmp_s != OP1_EQ_OP2);
      3'b100, 3'b110: taken_s = (cmp_s == OP1_LT_OP2);
      3'b101, 3'b111: taken_s = (cmp_s != OP1_LT_OP2);
      default:        illegal_s = 1'b1;
    endcase
    target_s   = s1_pc_r + s1_imm_r;
    misalign_s = taken_s & (target_s[1:0] != 2'b00);
  end

  // S1 operand stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r  <= 1'b0;
      s1_funct3_r <= 3'b000;
      s1_op1_r    <= {XLEN{1'b0}};
      s1_op2_r    <= {XLEN{1'b0}};
      s1_pc_r     <= {PC_W{1'b0}};
      s1_imm_r    <= {PC_W{1'b0}};
    end else begin
      if (flush) begin
        s1_valid_r <= 1'b0;
      end else if (accept_s) begin
        s1_valid_r <= 1'b1;
      end else if (s1_adv_s) begin
        s1_valid_r <= 1'b0;
      end
      if (accept_s) begin
        s1_funct3_r <= in_funct3;
        s1_op1_r    <= in_op1;
        s1_op2_r    <= in_op2;
        s1_pc_r     <= in_pc;
        s1_imm_r    <= in_imm;
      end
    end
  end

  // S2 result stage; data is only replaced when a live entry moves in, so it holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r    <= 1'b0;
      s2_taken_r    <= 1'b0;
      s2_target_r   <= {PC_W{1'b0}};
      s2_illegal_r  <= 1'b0;
      s2_misalign_r <= 1'b0;
    end else if (flush) begin
      s2_valid_r <= 1'b0;
    end else if (s1_adv_s) begin
      s2_valid_r    <= 1'b1;
      s2_taken_r    <= taken_s;
      s2_target_r   <= target_s;
      s2_illegal_r  <= illegal_s;
      s2_misalign_r <= misalign_s;
    end else if (out_ready) begin
      s2_valid_r <= 1'b0;
    end
  end

  // Saturating count of delivered taken branches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt_r <= {CNT_W{1'b0}};
    end else if (deliver_s && s2_taken_r && !flush && (taken_cnt_r != {CNT_W{1'b1}})) begin
      taken_cnt_r <= taken_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid    = s2_valid_r;
  assign out_taken    = s2_taken_r;
  assign out_target   = s2_target_r;
  assign out_illegal  = s2_illegal_r;
  assign out_misalign = s2_misalign_r;
  assign taken_cnt    = taken_cnt_r;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: inputs driven and outputs checked on the falling edge.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic [31:0] in_op1;
  logic [31:0] in_op2;
  logic [31:0] in_pc;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic        out_taken;
  logic [31:0] out_target;
  logic        out_illegal;
  logic        out_misalign;
  logic [1:0]  taken_cnt;

  int total_cnt;
  int bad_cnt;

  branch_resolve_unit #(.XLEN(32), .PC_W(32), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_op1(in_op1), .in_op2(in_op2), .in_pc(in_pc), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_target(out_target), .out_illegal(out_illegal), .out_misalign(out_misalign),
    .taken_cnt(taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pc, input logic [31:0] imm);
    in_valid  = 1'b1;
    in_funct3 = f3;
    in_op1    = a;
    in_op2    = b;
    in_pc     = pc;
    in_imm    = imm;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic tk,
                         input logic [31:0] tgt);
    chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, "_taken"}, {31'd0, out_taken}, {31'd0, tk});
    chk({tag, "_target"}, out_target, tgt);
  endtask

  logic [2:0]  v_f3  [4];
  logic [31:0] v_a   [4];
  logic [31:0] v_b   [4];
  logic [31:0] v_tgt [4];
  logic        v_tk  [4];

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_funct3 = 3'b000;
    in_op1    = 32'd0;
    in_op2    = 32'd0;
    in_pc     = 32'd0;
    in_imm    = 32'd0;
    out_ready = 1'b1;

    // Reset state
    step();
    chk_out("rst", 1'b0, 1'b0, 32'h0);
    chk("rst_illegal", {31'd0, out_illegal}, 32'd0);
    chk("rst_misalign", {31'd0, out_misalign}, 32'd0);
    chk("rst_cnt", {30'd0, taken_cnt}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // BEQ taken, two-edge latency
    step();
    send(3'b000, 32'h1234, 32'h1234, 32'h100, 32'h20);
    step();
    in_valid = 1'b0;
    chk("beq_lat1_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk_out("beq", 1'b1, 1'b1, 32'h120);
    chk("beq_misalign", {31'd0, out_misalign}, 32'd0);
    step();
    chk("beq_drain_valid", {31'd0, out_valid}, 32'd0);
    chk("beq_cnt", {30'd0, taken_cnt}, 32'd1);

    // Flush with both stages occupied
    out_ready = 1'b0;
    send(3'b000, 32'd7, 32'd7, 32'h400, 32'h10);
    step();
    send(3'b001, 32'd1, 32'd2, 32'h410, 32'h10);
    chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk_out("fl_pre", 1'b1, 1'b1, 32'h410);
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_valid0", {31'd0, out_valid}, 32'd0);
    chk("fl_cnt0", {30'd0, taken_cnt}, 32'd1);
    step();
    chk("fl_valid1", {31'd0, out_valid}, 32'd0);
    chk("fl_cnt1", {30'd0, taken_cnt}, 32'd1);

    // Illegal funct3 forces not-taken even with equal operands
    send(3'b010, 32'd5, 32'd5, 32'h500, 32'h8);
    step();
    in_valid = 1'b0;
    step();
    chk_out("ill", 1'b1, 1'b0, 32'h508);
    chk("ill_flag", {31'd0, out_illegal}, 32'd1);
    chk("ill_misalign", {31'd0, out_misalign}, 32'd0);
    step();
    chk("ill_cnt", {30'd0, taken_cnt}, 32'd1);

    // Back-to-back: BLT, BLTU, BGEU on 0x80000000 vs 0x7FFFFFFF, then BNE equal
    v_f3[0] = 3'b100; v_a[0] = 32'h8000_0000; v_b[0] = 32'h7FFF_FFFF; v_tk[0] = 1'b1; v_tgt[0] = 32'h204;
    v_f3[1] = 3'b110; v_a[1] = 32'h8000_0000; v_b[1] = 32'h7FFF_FFFF; v_tk[1] = 1'b0; v_tgt[1] = 32'h214;
    v_f3[2] = 3'b111; v_a[2] = 32'h8000_0000; v_b[2] = 32'h7FFF_FFFF; v_tk[2] = 1'b1; v_tgt[2] = 32'h224;
    v_f3[3] = 3'b001; v_a[3] = 32'd5;         v_b[3] = 32'd5;         v_tk[3] = 1'b0; v_tgt[3] = 32'h234;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        send(v_f3[k], v_a[k], v_b[k], 32'h200 + 32'(k) * 32'h10, 32'h4);
        chk($sformatf("b2b_in_ready%0d", k), {31'd0, in_ready}, 32'd1);
      end else begin
        in_valid = 1'b0;
      end
      if (k >= 2) begin
        chk_out($sformatf("b2b%0d", k - 2), 1'b1, v_tk[k-2], v_tgt[k-2]);
      end
      step();
    end
    chk("b2b_end_valid", {31'd0, out_valid}, 32'd0);
    chk("b2b_cnt", {30'd0, taken_cnt}, 32'd3);

    // Backpressure: 3 requests under 5 stalled cycles
    out_ready = 1'b0;
    send(3'b101, 32'd3, 32'hFFFF_FFFF, 32'h300, 32'h8);
    step();
    chk("bp_in_ready_b", {31'd0, in_ready}, 32'd1);
    send(3'b111, 32'd3, 32'hFFFF_FFFF, 32'h310, 32'h8);
    step();
    send(3'b000, 32'd1, 32'd2, 32'h320, 32'hFFFF_FFF0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_in_ready_c%0d", k), {31'd0, in_ready}, 32'd0);
      chk_out($sformatf("bp_hold%0d", k), 1'b1, 1'b1, 32'h308);
      step();
    end
    out_ready = 1'b1;
    chk_out("bp_a", 1'b1, 1'b1, 32'h308);
    step();
    in_valid = 1'b0;
    chk_out("bp_b", 1'b1, 1'b0, 32'h318);
    step();
    chk_out("bp_c", 1'b1, 1'b0, 32'h310);
    step();
    chk("bp_end_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_cnt_sat", {30'd0, taken_cnt}, 32'd3);

    // Target wrap and misalignment
    send(3'b000, 32'd9, 32'd9, 32'hFFFF_FFF0, 32'h14);
    step();
    send(3'b000, 32'd9, 32'd9, 32'hFFFF_FFF0, 32'h2);
    step();
    in_valid = 1'b0;
    chk_out("wrap", 1'b1, 1'b1, 32'h4);
    chk("wrap_misalign", {31'd0, out_misalign}, 32'd0);
    step();
    chk_out("mis", 1'b1, 1'b1, 32'hFFFF_FFF2);
    chk("mis_misalign", {31'd0, out_misalign}, 32'd1);
    step();
    chk("mis_cnt_sat", {30'd0, taken_cnt}, 32'd3);

    // Reset mid-flight drops the entry
    send(3'b000, 32'd1, 32'd1, 32'h600, 32'h4);
    step();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_cnt", {30'd0, taken_cnt}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("rst_mid_after", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
